// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction-fetch stage:
//   - ifu_state_e : fetch FSM states
//   - NOP_INSTR   : bubble instruction (sll $0,$0,0)
//   - ifid_t      : IF/ID pipeline register contents, also used by decode
//   - pc_plus4    : 32-bit modulo PC increment
// -----------------------------------------------------------------------------
package ifu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } ifu_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcPlus4;
      logic        valid;
   } ifid_t;

   localparam ifid_t IFID_RESET = '{instr: NOP_INSTR, pcPlus4: 32'h0000_0000, valid: 1'b0};

   // Wraps silently at the top of the address space; no carry out.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register with flush > stall > load priority; otherwise
// a bubble is inserted.
// Ports:
//   clock__i, reset_n__i : clock and async active-low reset
//   flush__i             : squash to bubble (PC+4 field kept)
//   stall__i             : hold all fields
//   load__i              : load loadData__i
//   loadData__i          : instruction / PC+4 / valid to load
//   ifid__o              : registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_register
   import ifu_pkg::*;
(
   input  logic  clock__i,
   input  logic  reset_n__i,
   input  logic  flush__i,
   input  logic  stall__i,
   input  logic  load__i,
   input  ifid_t loadData__i,
   output ifid_t ifid__o
);

   ifid_t ifid_d;
   ifid_t ifid_q;

   // Next-state selection; bubbles keep the PC+4 field untouched.
   always_comb begin
      ifid_d = ifid_q;
      if (flush__i) begin
         ifid_d.instr = NOP_INSTR;
         ifid_d.valid = 1'b0;
      end else if (stall__i) begin
         ifid_d = ifid_q;
      end else if (load__i) begin
         ifid_d = loadData__i;
      end else begin
         ifid_d.instr = NOP_INSTR;
         ifid_d.valid = 1'b0;
      end
   end

   // IF/ID flop bank.
   always_ff @(posedge clock__i or negedge reset_n__i) begin
      if (!reset_n__i) begin
         ifid_q <= IFID_RESET;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid__o = ifid_q;

endmodule

// File: rtl/ifu_protocol_checker.sv
// -----------------------------------------------------------------------------
// ifu_protocol_checker
// Simulation-only protocol monitor for the instruction-memory interface.
// Ports:
//   clock__i, reset_n__i : clock and async active-low reset
//   state__i             : current fetch FSM state
//   imemRvalid__i        : memory response valid
// -----------------------------------------------------------------------------
module ifu_protocol_checker
   import ifu_pkg::*;
(
   input  logic       clock__i,
   input  logic       reset_n__i,
   input  ifu_state_e state__i,
   input  logic       imemRvalid__i
);

   // A response is only legal while a fetch is outstanding.
   property p_rvalid_in_flight;
      @(posedge clock__i) disable iff (!reset_n__i)
         imemRvalid__i |-> (state__i == WAIT || state__i == DROP);
   endproperty

   a_rvalid_in_flight: assert property (p_rvalid_in_flight);

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage of the 5-stage MIPS pipeline. Fetches the instruction at pc__i over
// a req/gnt/rvalid memory interface (one fetch in flight), buffers it across a
// stall, and loads the IF/ID register. pcWrite__o advances the PC when a word
// is loaded into IF/ID, or whenever a flush redirects it.
// Ports:
//   clock__i, reset_n__i          : clock, async active-low reset
//   pc__i                         : current PC
//   pcWrite__o, pcPlus4__o        : PC write enable, pc__i + 4
//   imemReq__o, imemAddr__o       : fetch request and address
//   imemGnt__i, imemRvalid__i,
//   imemRdata__i                  : grant, response valid, response data
//   stall__i, flush__i            : hazard hold, branch/jump squash
//   ifidInstr__o, ifidPcPlus4__o,
//   ifidValid__o                  : IF/ID register contents
// -----------------------------------------------------------------------------
module instruction_fetch_unit
   import ifu_pkg::*;
(
   input  logic        clock__i,
   input  logic        reset_n__i,
   input  logic [31:0] pc__i,
   output logic        pcWrite__o,
   output logic [31:0] pcPlus4__o,
   output logic        imemReq__o,
   output logic [31:0] imemAddr__o,
   input  logic        imemGnt__i,
   input  logic        imemRvalid__i,
   input  logic [31:0] imemRdata__i,
   input  logic        stall__i,
   input  logic        flush__i,
   output logic [31:0] ifidInstr__o,
   output logic [31:0] ifidPcPlus4__o,
   output logic        ifidValid__o
);

   ifu_state_e  state_d;
   ifu_state_e  state_q;
   logic [31:0] pc4_d;
   logic [31:0] pc4_q;
   logic [31:0] hold_d;
   logic [31:0] hold_q;

   logic        load_s;
   logic [31:0] load_instr_s;
   logic        pc_write_s;
   logic        imem_req_s;
   ifid_t       load_data_s;
   ifid_t       ifid_s;

   assign pcPlus4__o  = pc_plus4(pc__i);
   assign imemAddr__o = pc__i;
   assign imemReq__o  = imem_req_s;
   assign pcWrite__o  = pc_write_s;

   // Fetch FSM next state; pcWrite tracks flush or a word delivered to IF/ID.
   always_comb begin
      state_d      = state_q;
      pc4_d        = pc4_q;
      hold_d       = hold_q;
      load_s       = 1'b0;
      load_instr_s = NOP_INSTR;
      pc_write_s   = 1'b0;
      imem_req_s   = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            // Request is masked during flush, so a grant cannot arrive then.
            imem_req_s = ~flush__i;
            if (flush__i) begin
               pc_write_s = 1'b1;
               state_d    = REQ;
            end else if (imemGnt__i) begin
               pc4_d   = pc_plus4(pc__i);
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (imemRvalid__i) begin
               if (flush__i) begin
                  pc_write_s = 1'b1;
                  state_d    = REQ;
               end else if (stall__i) begin
                  hold_d  = imemRdata__i;
                  state_d = HOLD;
               end else begin
                  load_s       = 1'b1;
                  load_instr_s = imemRdata__i;
                  pc_write_s   = 1'b1;
                  state_d      = REQ;
               end
            end else if (flush__i) begin
               // Response still owed by memory; swallow it in DROP.
               pc_write_s = 1'b1;
               state_d    = DROP;
            end else begin
               state_d = WAIT;
            end
         end
         HOLD: begin
            if (flush__i) begin
               pc_write_s = 1'b1;
               state_d    = REQ;
            end else if (!stall__i) begin
               load_s       = 1'b1;
               load_instr_s = hold_q;
               pc_write_s   = 1'b1;
               state_d      = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         DROP: begin
            pc_write_s = flush__i;
            if (imemRvalid__i) begin
               state_d = REQ;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, latched PC+4 and hold buffer.
   always_ff @(posedge clock__i or negedge reset_n__i) begin
      if (!reset_n__i) begin
         state_q <= IDLE;
         pc4_q   <= 32'h0000_0000;
         hold_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc4_q   <= pc4_d;
         hold_q  <= hold_d;
      end
   end

   assign load_data_s = '{instr: load_instr_s, pcPlus4: pc4_q, valid: 1'b1};

   if_id_register u_if_id_register (
      .clock__i    (clock__i),
      .reset_n__i  (reset_n__i),
      .flush__i    (flush__i),
      .stall__i    (stall__i),
      .load__i     (load_s),
      .loadData__i (load_data_s),
      .ifid__o     (ifid_s)
   );

   assign ifidInstr__o   = ifid_s.instr;
   assign ifidPcPlus4__o = ifid_s.pcPlus4;
   assign ifidValid__o   = ifid_s.valid;

   ifu_protocol_checker u_ifu_protocol_checker (
      .clock__i      (clock__i),
      .reset_n__i    (reset_n__i),
      .state__i      (state_q),
      .imemRvalid__i (imemRvalid__i)
   );

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting between the program counter and the decode stage. It takes the current PC from the program counter, fetches the instruction over a request/grant/response instruction-memory interface with wait states, and loads the IF/ID pipeline register. It drives the program counter's write enable so the PC advances only when an instruction has been accepted, or when a flush redirects it. Only one fetch is in flight at any time.

## Interface
- NOP_INSTR, 32'h0000_0000 — bubble instruction (sll $0,$0,0) loaded into IF/ID on reset, flush or empty cycle.
- clock__i  input  1  — single clock, rising edge.
- reset_n__i  input  1  — asynchronous, active-low reset.
- pc__i  input  32  — current PC from the program counter; stable until a cycle with pcWrite__o=1.
- pcWrite__o  output  1  — write enable to the program counter.
- pcPlus4__o  output  32  — pc__i + 4, combinational, to the next-PC mux.
- imemReq__o  output  1  — fetch request.
- imemAddr__o  output  32  — fetch address, equal to pc__i.
- imemGnt__i  input  1  — request accepted this cycle.
- imemRvalid__i  input  1  — response valid, at least 1 cycle after grant.
- imemRdata__i  input  32  — instruction word.
- stall__i  input  1  — hazard unit: hold IF/ID.
- flush__i  input  1  — branch/jump taken: squash IF/ID and any in-flight fetch; next-PC mux selects the target.
- ifidInstr__o  output  32  — IF/ID instruction.
- ifidPcPlus4__o  output  32  — IF/ID PC+4.
- ifidValid__o  output  1  — IF/ID holds a real instruction.

## Operation
- **IDLE**: entered only by reset. Drives no request. Moves to REQ on the first clock after reset release.
- **REQ**: imemReq__o = ~flush__i and imemAddr__o = pc__i.
  - gnt=1, no flush: go to WAIT and latch pc__i+4 internally.
  - flush=1: request is masked, so no grant is possible; pcWrite__o=1; stay in REQ and re-issue next cycle at the new PC.
- **WAIT**: waiting for the response.
  - rvalid=1, flush=1: discard the word; pcWrite__o=1; go to REQ.
  - rvalid=1, stall=1: capture the word into a hold buffer; go to HOLD.
  - rvalid=1, neither: load IF/ID with the word and latched PC+4, valid=1; pcWrite__o=1; go to REQ.
  - flush=1, no rvalid: pcWrite__o=1; go to DROP.
- **HOLD**: buffered instruction waiting for the stall to clear.
  - flush=1: discard the buffer; pcWrite__o=1; go to REQ.
  - stall=0: load IF/ID from the buffer; pcWrite__o=1; go to REQ.
- **DROP**: discard the next rvalid word, then go to REQ. pcWrite__o=0. The flush was already applied on entry, and a further flush here re-asserts pcWrite__o=1.
- IF/ID update priority:
  - flush → bubble (NOP_INSTR, valid=0, PC+4 unchanged).
  - else stall → hold all fields.
  - else load, when a word is delivered.
  - else bubble (valid=0, instr=NOP).
- pcWrite__o = flush__i | (word loaded into IF/ID this cycle). It is never asserted in IDLE.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no carry out.
- Flush always beats stall.

## Timing
- Reset (asynchronous): state=IDLE, ifidInstr__o=NOP_INSTR, ifidPcPlus4__o=0, ifidValid__o=0, hold buffer cleared. Combinationally during reset: imemReq__o=0, pcWrite__o=0.
- Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): one instruction every 2 cycles. IF/ID is valid on the clock edge ending the rvalid cycle.
- Each wait cycle before grant, or between grant and rvalid, adds 1 cycle.
- imemAddr__o is stable while imemReq__o=1 and no grant has occurred, because PC only changes with pcWrite__o.
- rvalid outside WAIT/DROP is a protocol error: it is ignored, and an assertion fires in simulation.
- Reset mid-fetch returns the unit to IDLE. Any later response from the aborted fetch is the memory's responsibility, since memory is reset with the same signal.

## Structure
- Package ifu_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD, DROP);
  - the NOP_INSTR default constant;
  - a packed struct ifid_t {instr, pcPlus4, valid}, shared with the decode stage.
- Sub-module if_id_register: the flop bank with async reset and flush/stall/load priority. The FSM and hold buffer live in instruction_fetch_unit.

## Test plan
- **Reset and first fetch.** Release reset with pc__i=0 and zero-wait memory.
  - Cycle 0: imemReq__o=0.
  - Cycle 1: imemReq__o=1 with addr 0.
  - After rvalid with data 32'h2008_0005: ifidInstr=32'h2008_0005, ifidPcPlus4=4, valid=1, and a single-cycle pcWrite pulse.
- **Wait states.** gnt 3 cycles late and rvalid 2 cycles after grant: address held constant, no pcWrite until rvalid, IF/ID bubbles meanwhile.
- **Stall during response.** stall=1 for 4 cycles starting at rvalid: IF/ID holds its old value, the word is buffered and pcWrite=0. On stall release, IF/ID loads the word and pcWrite pulses once.
- **Flush in WAIT before rvalid.** pcWrite=1 in the flush cycle; the next rvalid word (32'hDEAD_BEEF) never appears in IF/ID; the next request uses the new pc__i.
- **Flush with stall together in HOLD.** IF/ID becomes NOP with valid=0, the buffer is discarded and pcWrite=1.
- **Wrap-around.** pc__i=32'hFFFF_FFFC gives pcPlus4__o=0 and ifidPcPlus4=0. Asserting reset mid-WAIT gives all outputs at their reset values immediately.
